cs_measure: RTL and testbench

Compressive-sensing measurement stage sitting between the SPI byte receiver and the SPI byte sender. It consumes a frame of `N_SAMPLES` received sample bytes and accumulates `M_MEAS` random ±1 projections (Bernoulli sensing matrix generated by an LFSR). It then streams the `M_MEAS` signed measurements to the sender over a valid/ready handshake. The matrix is identical for every frame, so the reconstruction side can regenerate Phi from the seed.

---
 rtl/cs_pkg.sv | 19 +
 rtl/cs_lfsr16.sv | 30 +++
 rtl/cs_measure.sv | 130 +++++++++++++
 tb/tb_cs_measure.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// cs_pkg: shared types and constants for the compressive-sensing measurement
// stage (state encoding, LFSR taps, default seed, accumulator width helper).
package cs_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } cs_state_t;

  // Galois right-shift feedback mask for the 16-bit sensing-matrix LFSR.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Sign bit + sample bits + growth from summing n_samples terms.
  function automatic int acc_width(input int data_w, input int n_samples);
    return data_w + $clog2(n_samples) + 1;
  endfunction

endpackage

// File: rtl/cs_lfsr16.sv
// cs_lfsr16: 16-bit Galois LFSR (right shift, taps LFSR_TAPS) producing the
// Bernoulli +/-1 sensing-matrix rows.
// Ports:
//   clk, rst_n  - clock, async active-low reset (state returns to seed)
//   load        - reload seed (priority over advance)
//   advance     - step the LFSR once
//   seed        - reload / reset value
//   state       - current LFSR state
module cs_lfsr16
  import cs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= seed;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/cs_measure.sv
// cs_measure: accumulates M_MEAS random +/-1 projections over a frame of
// N_SAMPLES sample bytes, then streams the signed measurements out over a
// valid/ready handshake. The LFSR reseeds every frame so the matrix repeats.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_valid, in_data    - sample strobe and byte
//   in_ready             - high while samples are accepted (ACCUM)
//   meas_valid/data/ready- measurement output handshake (ACC_W-bit signed)
//   frame_done           - one-cycle pulse after the last measurement transfer
//   overrun              - sticky: sample arrived outside ACCUM
// Build option: CS_MEAS_ZERO_MEAN_EN treats samples as offset-binary
// (MSB inverted, sign-extended) instead of unsigned.
module cs_measure
  import cs_pkg::*;
#(
  parameter int          N_SAMPLES = 64,
  parameter int          M_MEAS    = 16,
  parameter int          DATA_W    = 8,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED,
  localparam int         ACC_W     = acc_width(DATA_W, N_SAMPLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              meas_valid,
  output logic [ACC_W-1:0]  meas_data,
  input  logic              meas_ready,
  output logic              frame_done,
  output logic              overrun
);

  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam int IDX_W = (M_MEAS > 1) ? $clog2(M_MEAS) : 1;

  cs_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_inc;
  logic [ACC_W-1:0]  acc     [M_MEAS];
  logic [ACC_W-1:0]  acc_nxt [M_MEAS];
  logic [ACC_W-1:0]  s;
  logic [15:0]       lfsr;
  logic              accept;
  logic              last_sample;
  logic              xfer;
  logic              last_xfer;

  assign accept      = in_valid && (state == ACCUM);
  assign last_sample = accept && (cnt == CNT_W'(N_SAMPLES - 1));
  assign xfer        = (state == DRAIN) && meas_valid && meas_ready;
  assign last_xfer   = xfer && (idx == IDX_W'(M_MEAS - 1));
  assign idx_inc     = idx + 1'b1;

`ifdef CS_MEAS_ZERO_MEAN_EN
  assign s = {{(ACC_W - DATA_W){~in_data[DATA_W-1]}}, ~in_data[DATA_W-1], in_data[DATA_W-2:0]};
`else
  assign s = {{(ACC_W - DATA_W){1'b0}}, in_data};
`endif

  // LFSR bit k picks the sign for measurement k: 0 adds, 1 subtracts.
  always_comb begin
    for (int unsigned k = 0; k < M_MEAS; k++) begin
      acc_nxt[k] = lfsr[k] ? (acc[k] - s) : (acc[k] + s);
    end
  end

  cs_lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (last_xfer),
    .advance (accept),
    .seed    (LFSR_SEED),
    .state   (lfsr)
  );

  // meas_data is loaded from the post-update accumulator on the last sample
  // so the first measurement is ready on the same edge meas_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      cnt        <= '0;
      idx        <= '0;
      in_ready   <= 1'b1;
      meas_valid <= 1'b0;
      meas_data  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned k = 0; k < M_MEAS; k++) acc[k] <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ACCUM: begin
          if (accept) begin
            for (int unsigned k = 0; k < M_MEAS; k++) acc[k] <= acc_nxt[k];
            cnt <= cnt + 1'b1;
            if (last_sample) begin
              state      <= DRAIN;
              idx        <= '0;
              in_ready   <= 1'b0;
              meas_valid <= 1'b1;
              meas_data  <= acc_nxt[0];
            end
          end
        end
        DRAIN: begin
          if (in_valid) overrun <= 1'b1;
          if (xfer) begin
            if (last_xfer) begin
              for (int unsigned k = 0; k < M_MEAS; k++) acc[k] <= '0;
              cnt        <= '0;
              idx        <= '0;
              state      <= ACCUM;
              in_ready   <= 1'b1;
              meas_valid <= 1'b0;
              meas_data  <= '0;
              frame_done <= 1'b1;
            end else begin
              idx       <= idx_inc;
              meas_data <= acc[idx_inc];
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_measure.sv
module tb_cs_measure;
  localparam int N  = 64;
  localparam int M  = 16;
  localparam int AW = 15;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          meas_ready = 1'b0;
  logic          in_ready;
  logic          meas_valid;
  logic [AW-1:0] meas_data;
  logic          frame_done;
  logic          overrun;

  always #5 clk = ~clk;

  cs_measure #(
    .N_SAMPLES (N),
    .M_MEAS    (M),
    .DATA_W    (8),
    .LFSR_SEED (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .meas_valid (meas_valid),
    .meas_data  (meas_data),
    .meas_ready (meas_ready),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  int vectors = 0;
  int errs    = 0;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int sval(input logic [7:0] d);
`ifdef CS_MEAS_ZERO_MEAN_EN
    return int'(d) - 128;
`else
    return int'(d);
`endif
  endfunction

  int            smp[$];
  logic [AW-1:0] exp_q[$];
  bit            exp_drain, exp_done, exp_ovr;

  function automatic void push_frame();
    int acc[M];
    logic [15:0] st;
    st = SEED;
    for (int k = 0; k < M; k++) acc[k] = 0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < M; k++) acc[k] += st[k] ? -smp[i] : smp[i];
      st = lfsr_step(st);
    end
    for (int k = 0; k < M; k++) exp_q.push_back(AW'(acc[k]));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp.delete();
      exp_q.delete();
      exp_drain = 0;
      exp_done  = 0;
      exp_ovr   = 0;
    end else begin
      exp_done = 0;
      if (!exp_drain) begin
        if (in_valid) begin
          smp.push_back(sval(in_data));
          if (smp.size() == N) begin
            push_frame();
            smp.delete();
            exp_drain = 1;
          end
        end
      end else begin
        if (in_valid) exp_ovr = 1;
        if (meas_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            exp_drain = 0;
            exp_done  = 1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, !exp_drain);
      check("meas_valid", meas_valid, exp_drain);
      if (exp_drain && exp_q.size() > 0)
        check("meas_data", $signed(meas_data), $signed(exp_q[0]));
      check("frame_done", frame_done, exp_done);
      check("overrun", overrun, exp_ovr);
    end
  end

  // Transfer capture and frame_done pulse counting.
  logic [AW-1:0] cap[$];
  int            done_cnt = 0;
  always @(negedge clk) begin
    if (rst_n && meas_valid && meas_ready) cap.push_back(meas_data);
    if (rst_n && frame_done) done_cnt++;
  end

  // ---------------- stimulus ----------------
  logic [7:0]    fr[N];
  logic [AW-1:0] ref_a[M];

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = fr[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int stall, input bit ovr_pulse);
    logic [AW-1:0] first;
    bit got;
    cap.delete();
    meas_ready = 1'b0;
    first = meas_data;
    for (int j = 0; j < stall; j++) begin
      if (ovr_pulse && j == 0) begin
        in_valid = 1'b1;
        in_data  = 8'h5A;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stall_valid", meas_valid, 1);
      check("stall_hold", meas_data, first);
    end
    meas_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (frame_done) begin
        got = 1;
        break;
      end
    end
    meas_ready = 1'b0;
    check("drain_timeout", got, 1);
    check("cap_count", cap.size(), M);
  endtask

  task automatic run_frame_and_compare(input string name);
    send(N);
    drain(0, 0);
    for (int k = 0; k < M && k < cap.size(); k++)
      check(name, $signed(cap[k]), $signed(ref_a[k]));
  endtask

  int lit10[M] = '{-10, 10, 10, 10, 10, -10, -10, -10, 10, 10, -10, -10, 10, -10, 10, -10};

  initial begin
    int ones;
    logic [15:0] st;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_meas_data", meas_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef CS_MEAS_ZERO_MEAN_EN
    for (int i = 0; i < N; i++) fr[i] = 8'h80;
    send(N);
    drain(0, 0);
    for (int k = 0; k < M && k < cap.size(); k++) check("zm_mid", $signed(cap[k]), 0);
`else
    // All-zero frame: every measurement zero, exactly one done pulse.
    for (int i = 0; i < N; i++) fr[i] = 8'h00;
    done_cnt = 0;
    send(N);
    drain(0, 0);
    for (int k = 0; k < M && k < cap.size(); k++) check("zero_frame", $signed(cap[k]), 0);
    @(posedge clk); #1;
    check("done_pulses", done_cnt, 1);

    // Impulse at sample 0 exposes the seed bits; also stalls for 5 cycles.
    fr[0] = 8'd10;
    send(N);
    drain(5, 0);
    for (int k = 0; k < M && k < cap.size(); k++) check("impulse", $signed(cap[k]), lit10[k]);

    // Full-scale frame: m0 = 255*(64 - 2*ones(bit0)).
    for (int i = 0; i < N; i++) fr[i] = 8'hFF;
    ones = 0;
    st = SEED;
    for (int i = 0; i < N; i++) begin
      ones += int'(st[0]);
      st = lfsr_step(st);
    end
    send(N);
    drain(0, 0);
    if (cap.size() > 0) check("fullscale_m0", $signed(cap[0]), 255 * (N - 2 * ones));
`endif

    // Reference stream for a varied pattern, run clean.
    for (int i = 0; i < N; i++) fr[i] = 8'((i * 37 + 11) & 255);
    send(N);
    drain(0, 0);
    for (int k = 0; k < M; k++) ref_a[k] = (k < cap.size()) ? cap[k] : '0;

    // Same pattern with a dropped sample during drain; next frame must match.
    send(N);
    drain(3, 1);
    check("overrun_set", overrun, 1);
    run_frame_and_compare("after_overrun");
    check("overrun_sticky", overrun, 1);

    // Reset after 30 samples, then the full frame must match the reference.
    send(30);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame_and_compare("after_reset");
    run_frame_and_compare("repeat_frame");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
